// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the load/store front end.
package mem_pkg;

   localparam int unsigned DEF_WORDS  = 128;
   localparam int unsigned DEF_ADDR_W = 9;
   localparam int unsigned DATA_W     = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WSETUP,
      ST_WPULSE,
      ST_WHOLD,
      ST_RESP
   } state_e;

   // Illegal size or a lane that does not match the access alignment.
   function automatic logic req_misaligned(input size_e size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lane[0];
         SZ_WORD: return lane != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between the CPU datapath and the unit.
interface mem_access_unit_if
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
module lane_align
   import mem_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  logic [1:0]        lane,
   input  size_e             size,
   input  logic              sgn,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_data_c,
   output logic [DATA_W-1:0] store_word_c
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Select the addressed byte and half from the RAM word.
   always_comb begin
      byte_v = word[7:0];
      case (lane)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      half_v = lane[1] ? word[31:16] : word[15:0];
   end

   // Right-align the selected lane and extend it.
   always_comb begin
      load_data_c = word;
      case (size)
         SZ_BYTE: load_data_c = {{24{sgn & byte_v[7]}}, byte_v};
         SZ_HALF: load_data_c = {{16{sgn & half_v[15]}}, half_v};
         default: load_data_c = word;
      endcase
   end

   // Overlay the low byte/half of the store data onto the old word.
   always_comb begin
      store_word_c = wdata;
      case (size)
         SZ_BYTE: begin
            store_word_c = word;
            case (lane)
               2'd0:    store_word_c[7:0]   = wdata[7:0];
               2'd1:    store_word_c[15:8]  = wdata[7:0];
               2'd2:    store_word_c[23:16] = wdata[7:0];
               default: store_word_c[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            store_word_c = word;
            if (lane[1]) store_word_c[31:16] = wdata[15:0];
            else         store_word_c[15:0]  = wdata[15:0];
         end
         default: store_word_c = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a 32-bit word RAM with a level-sensitive write strobe.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned WORDS  = DEF_WORDS,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_unit_if.slave  bus,
   output logic [DATA_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              ram_rw
);

   localparam int unsigned IDX_W = $clog2(WORDS);

   state_e              state;
   logic                we_q;
   size_e               size_q;
   logic                sgn_q;
   logic [1:0]          lane_q;
   logic [DATA_W-1:0]   wdata_q;

   logic [ADDR_W-1:0]   addr_c;
   logic [IDX_W-1:0]    idx_c;
   size_e               size_c;
   logic                err_c;
   logic [DATA_W-1:0]   load_data_c;
   logic [DATA_W-1:0]   store_word_c;

   assign addr_c = bus.req_addr;
   assign idx_c  = addr_c[IDX_W+1:2];
   assign size_c = size_e'(bus.req_size);
   assign err_c  = req_misaligned(size_c, addr_c[1:0]);

   lane_align u_lane_align (
      .word         (ram_dout),
      .lane         (lane_q),
      .size         (size_q),
      .sgn          (sgn_q),
      .wdata        (wdata_q),
      .load_data_c  (load_data_c),
      .store_word_c (store_word_c)
   );

   // Access sequencer: read / setup / pulse / hold / respond, all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
         ram_addr       <= '0;
         ram_din        <= '0;
         ram_rw         <= 1'b0;
         we_q           <= 1'b0;
         size_q         <= SZ_BYTE;
         sgn_q          <= 1'b0;
         lane_q         <= '0;
         wdata_q        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  bus.req_ready <= 1'b0;
                  we_q          <= bus.req_we;
                  size_q        <= size_c;
                  sgn_q         <= bus.req_signed;
                  lane_q        <= addr_c[1:0];
                  wdata_q       <= bus.req_wdata;
                  if (err_c) begin
                     // Rejected request: respond immediately, RAM untouched.
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                     bus.resp_rdata <= '0;
                     state          <= ST_RESP;
                  end else begin
                     ram_addr <= DATA_W'(idx_c);
                     if (bus.req_we && size_c == SZ_WORD) begin
                        ram_din <= bus.req_wdata;
                        state   <= ST_WSETUP;
                     end else begin
                        state <= ST_READ;
                     end
                  end
               end
            end
            ST_READ: begin
               if (we_q) begin
                  ram_din <= store_word_c;
                  state   <= ST_WSETUP;
               end else begin
                  bus.resp_rdata <= load_data_c;
                  bus.resp_err   <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  state          <= ST_RESP;
               end
            end
            ST_WSETUP: begin
               ram_rw <= 1'b1;
               state  <= ST_WPULSE;
            end
            ST_WPULSE: begin
               ram_rw <= 1'b0;
               state  <= ST_WHOLD;
            end
            ST_WHOLD: begin
               bus.resp_rdata <= '0;
               bus.resp_err   <= 1'b0;
               bus.resp_valid <= 1'b1;
               state          <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  bus.req_ready  <= 1'b1;
                  state          <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: cycle-level reference model plus directed vectors.
module tb_mem_access_unit;

   localparam int INF = 1 << 30;

   logic        clk;
   logic        rst_n;
   logic [31:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;
   logic        ram_rw;

   logic [31:0] ram     [128];
   logic [31:0] ref_mem [128];

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   bit mon_en = 0;

   // Reference model state for the request in flight.
   int          m_acc = 0;
   int          m_hs  = 0;
   int          m_due = INF;
   int          m_rw  = -10;
   logic [31:0] m_addr = '0;
   logic [31:0] m_din  = '0;
   logic [31:0] m_rdata = '0;
   logic        m_err  = 1'b0;

   mem_access_unit_if #(.ADDR_W(9)) bus ();

   mem_access_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout),
      .ram_rw   (ram_rw)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // RAM: combinational read, write while the strobe is high at a clock edge.
   assign ram_dout = ram[ram_addr[6:0]];
   always @(posedge clk) if (ram_rw) ram[ram_addr[6:0]] <= ram_din;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
   endtask

   function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] size, input logic sgn);
      logic [31:0] v;
      v = w >> (8 * int'(lane));
      if (size == 2'b00) return (sgn && v[7])  ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
      if (size == 2'b01) return (sgn && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
      return w;
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] mask;
      int          sh;
      if (size == 2'b10) return wd;
      mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
      sh   = 8 * int'(lane);
      return (old & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   // Expected response and RAM activity for a request accepted at edge number acc.
   // Latencies count the accept edge as the first cycle.
   task automatic accept_model(input int acc, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [8:0] addr, input logic [31:0] wd);
      logic err;
      int   idx;
      err   = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
      idx   = int'(addr) / 4;
      m_acc = acc;
      m_hs  = INF;
      m_err = err;
      m_rdata = '0;
      m_rw  = -10;
      if (err) begin
         m_due = acc + 1 - 1;
      end else if (!we) begin
         m_due   = acc + 2 - 1;
         m_rdata = f_load(ref_mem[idx], addr[1:0], size, sgn);
      end else begin
         m_din  = f_merge(ref_mem[idx], wd, addr[1:0], size);
         m_addr = 32'(idx);
         ref_mem[idx] = m_din;
         m_rw   = (size == 2'b10) ? acc + 1 : acc + 2;
         m_due  = (size == 2'b10) ? acc + 4 - 1 : acc + 5 - 1;
      end
   endtask

   task automatic model_reset();
      m_acc = 0;
      m_hs  = 0;
      m_due = INF;
      m_rw  = -10;
   endtask

   // Per-cycle compare of every DUT output against the model.
   int c;
   bit busy;
   bit vld;
   always @(posedge clk) begin
      #2;
      if (mon_en && rst_n) begin
         c    = cyc;
         busy = (c >= m_acc) && (c < m_hs);
         vld  = (c >= m_due) && (c < m_hs);
         check("req_ready", 32'(bus.req_ready), 32'(!busy));
         check("resp_valid", 32'(bus.resp_valid), 32'(vld));
         check("ram_rw", 32'(ram_rw), 32'(c == m_rw));
         if (vld) begin
            check("resp_rdata", bus.resp_rdata, m_rdata);
            check("resp_err", 32'(bus.resp_err), 32'(m_err));
         end
         if (m_rw >= 0 && c >= m_rw - 1 && c <= m_rw + 1) begin
            check("ram_addr", ram_addr, m_addr);
            check("ram_din", ram_din, m_din);
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [8:0] addr, input logic [31:0] wd, output bit ok);
      int n;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = bus.req_ready;
      if (!ok) begin
         check("req_accept", 32'(bus.req_ready), 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      accept_model(cyc + 1, we, size, sgn, addr, wd);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = 9'($urandom);
      bus.req_wdata = $urandom;
      bus.req_size  = 2'($urandom);
   endtask

   task automatic finish_resp(input int hold, output logic [31:0] got, output logic gerr);
      while (cyc < m_due) @(negedge clk);
      repeat (hold) @(negedge clk);
      got  = bus.resp_rdata;
      gerr = bus.resp_err;
      bus.resp_ready = 1'b1;
      m_hs = cyc + 1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [8:0] addr, input logic [31:0] wd, input int hold,
                         output logic [31:0] got, output logic gerr);
      bit ok;
      issue(we, size, sgn, addr, wd, ok);
      if (ok) finish_resp(hold, got, gerr);
      else begin
         got  = 'x;
         gerr = 1'bx;
      end
   endtask

   logic [31:0] g;
   logic        e;
   logic [31:0] old_w;
   bit          ok;

   initial begin
      for (int i = 0; i < 128; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_resp_err", 32'(bus.resp_err), 32'd0);
      check("rst_ram_rw", 32'(ram_rw), 32'd0);
      check("rst_ram_addr", ram_addr, 32'd0);
      check("rst_ram_din", ram_din, 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Word store then load.
      do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEAD_BEEF, 0, g, e);
      do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 0, g, e);
      check("word_load", g, 32'hDEAD_BEEF);

      // Byte read-modify-write and byte loads.
      do_req(1'b1, 2'b10, 1'b0, 9'h014, 32'h1122_3344, 0, g, e);
      do_req(1'b1, 2'b00, 1'b0, 9'h016, 32'h0000_00AA, 0, g, e);
      do_req(1'b0, 2'b10, 1'b0, 9'h014, 32'h0, 0, g, e);
      check("byte_rmw_word", g, 32'h11AA_3344);
      do_req(1'b0, 2'b00, 1'b1, 9'h016, 32'h0, 0, g, e);
      check("byte_load_s", g, 32'hFFFF_FFAA);
      do_req(1'b0, 2'b00, 1'b0, 9'h016, 32'h0, 0, g, e);
      check("byte_load_u", g, 32'h0000_00AA);

      // Half store to the upper half and half loads.
      do_req(1'b1, 2'b01, 1'b0, 9'h01E, 32'h0000_8001, 0, g, e);
      do_req(1'b0, 2'b10, 1'b0, 9'h01C, 32'h0, 0, g, e);
      check("half_rmw_word", g, 32'h8001_0000);
      do_req(1'b0, 2'b01, 1'b1, 9'h01E, 32'h0, 0, g, e);
      check("half_load_s", g, 32'hFFFF_8001);
      do_req(1'b0, 2'b01, 1'b0, 9'h01E, 32'h0, 0, g, e);
      check("half_load_u", g, 32'h0000_8001);

      // Error cases.
      do_req(1'b0, 2'b01, 1'b0, 9'h003, 32'h0, 0, g, e);
      check("err_half_flag", 32'(e), 32'd1);
      check("err_half_rdata", g, 32'd0);
      do_req(1'b0, 2'b11, 1'b0, 9'h004, 32'h0, 0, g, e);
      check("err_size_flag", 32'(e), 32'd1);
      do_req(1'b1, 2'b10, 1'b0, 9'h000, 32'hCAFE_F00D, 0, g, e);
      do_req(1'b1, 2'b10, 1'b0, 9'h002, 32'h1111_1111, 0, g, e);
      check("err_store_flag", 32'(e), 32'd1);
      do_req(1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 0, g, e);
      check("err_store_kept", g, 32'hCAFE_F00D);

      // Response backpressure.
      do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 5, g, e);
      check("bp_load", g, 32'hDEAD_BEEF);

      // Reset during the write pulse.
      old_w = ref_mem[16];
      issue(1'b1, 2'b10, 1'b0, 9'h040, 32'h1234_5678, ok);
      if (ok) begin
         while (cyc < m_rw) @(negedge clk);
         check("pulse_before_rst", 32'(ram_rw), 32'd1);
         mon_en = 1'b0;
         rst_n  = 1'b0;
         #1;
         check("arst_ram_rw", 32'(ram_rw), 32'd0);
         check("arst_ram_addr", ram_addr, 32'd0);
         check("arst_ram_din", ram_din, 32'd0);
         check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
         check("arst_req_ready", 32'(bus.req_ready), 32'd1);
         ref_mem[16] = old_w;
         model_reset();
         @(negedge clk);
         rst_n  = 1'b1;
         mon_en = 1'b1;
      end
      do_req(1'b0, 2'b10, 1'b0, 9'h040, 32'h0, 0, g, e);
      check("abandoned_store", g, 32'h0000_0000);
      do_req(1'b1, 2'b10, 1'b0, 9'h040, 32'h0BAD_CAFE, 0, g, e);
      do_req(1'b0, 2'b10, 1'b0, 9'h040, 32'h0, 0, g, e);
      check("post_rst_store", g, 32'h0BAD_CAFE);

      // Full sweep of every word.
      for (int i = 0; i < 128; i++) do_req(1'b1, 2'b10, 1'b0, 9'(i * 4), $urandom, 0, g, e);
      for (int i = 0; i < 128; i++) do_req(1'b0, 2'b10, 1'b0, 9'(i * 4), 32'h0, 0, g, e);
      for (int i = 0; i < 128; i++) check("ram_contents", ram[i], ref_mem[i]);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
